rr_arbiter16: RTL
=================

RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 SHALL have parameter: HOLD_MAX, 8, maximum grant tenure in cycles before forced revocation (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  16  request lines; bit i = requester i.
REQ-005 SHALL have port: done  input  1  release pulse from the current grant holder.
REQ-006 SHALL have port: grant  output  16  registered one-hot grant, decoded from grant_idx.
REQ-007 SHALL have port: grant_idx  output  4  index of the current grant holder.
REQ-008 SHALL have port: grant_valid  output  1  high while any grant is active.
REQ-009 SHALL have port: timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Function
REQ-010 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-011 SHALL keep a 4-bit priority pointer ptr; search order is ptr, ptr+1, ..., ptr+15, mod 16.
REQ-012 In IDLE with req != 0, SHALL select the first set bit in search order and enter BUSY on that edge.
REQ-013 Grant latency SHALL be exactly 1 cycle: req sampled at edge N, so grant/grant_idx/grant_valid are valid after edge N.
REQ-014 In IDLE with req == 0, SHALL stay in IDLE with grant = 0 and grant_valid = 0.
REQ-015 grant SHALL equal 16'b1 << grant_idx when grant_valid = 1, and 16'h0000 otherwise; it is never multi-hot.
REQ-016 In BUSY, SHALL hold grant_idx stable while req[grant_idx] = 1, done = 0, and the hold count < HOLD_MAX.
REQ-017 BUSY SHALL release (-> IDLE) on the first edge where done = 1, req[grant_idx] = 0, or the hold count reaches HOLD_MAX.
REQ-018 Hold counter: 8-bit; SHALL load 1 on entry to BUSY, increment each BUSY cycle, and saturate (no wrap).
REQ-019 On release, SHALL set ptr = grant_idx + 1 mod 16; index 15 SHALL wrap to 0.
REQ-020 On release by HOLD_MAX only (done = 0 and req still high), SHALL pulse timeout for the one cycle following the release edge.
REQ-021 If done and the HOLD_MAX limit coincide, release SHALL count as normal and timeout SHALL stay 0.
REQ-022 Every release SHALL be followed by at least one IDLE cycle with grant_valid = 0; there are no back-to-back grants.
REQ-023 Requests changing on non-holder bits during BUSY SHALL NOT affect the grant.
REQ-024 done asserted in IDLE SHALL be ignored.

Reset
REQ-025 rst_n = 0 SHALL immediately, without a clock edge, force: state = IDLE, ptr = 0, counter = 0, grant = 16'h0000, grant_idx = 0, grant_valid = 0, timeout = 0.
REQ-026 Reset asserted mid-BUSY SHALL drop grant asynchronously; after deassertion, arbitration SHALL restart from ptr = 0.
REQ-027 Release from reset SHALL be synchronous to clk; the first grant can occur on the first edge after rst_n rises.

Verification
REQ-028 SHALL test: req = 16'h0101 held, done pulsed each tenure -> grants alternate idx 0, 8, 0, 8, with one idle cycle between each.
REQ-029 SHALL test: ptr = 15 after idx 14 release, req = 16'h8001 -> idx 15 granted, then wrap to idx 0.
REQ-030 SHALL test: HOLD_MAX = 8, req[3] held, no done -> grant_idx = 3 for 8 cycles, timeout pulse once, then next requester or idle.
REQ-031 SHALL test: done and HOLD_MAX coinciding -> release occurs and timeout = 0.
REQ-032 SHALL test: rst_n = 0 between edges while BUSY -> grant = 0 immediately; after release, req = 16'hFFFF -> idx 0 granted.
REQ-033 SHALL test: all 16 single-bit req values -> grant = 16'b1 << i and grant_idx = i, one-hot checked every cycle.

Source files
------------

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with a bounded grant tenure.
// A released holder hands priority to its successor.
module rr_arbiter16 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] grant,
  output logic [3:0]  grant_idx,
  output logic        grant_valid,
  output logic        timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     nxt_state;
  logic [3:0] ptr;
  logic [3:0] nxt_ptr;
  logic [3:0] idx;
  logic [3:0] nxt_idx;
  logic [7:0] cnt;
  logic [7:0] nxt_cnt;
  logic       to_q;
  logic       nxt_to;

  logic [31:0] dbl;
  logic [15:0] rot;
  logic [3:0]  off;
  logic [3:0]  pick;
  logic        hold_hit;
  logic        rel;

  // first requester at or after ptr, found in rotated space
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: 16];
    off = 4'd0;
    for (int j = 15; j >= 0; j--) begin
      if (rot[j]) off = 4'(j);
    end
    pick = ptr + off;
  end

  // tenure limit and release condition for the holder
  always_comb begin
    hold_hit = (cnt >= 8'(HOLD_MAX));
    rel      = done || !req[idx] || hold_hit;
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 4'd0;
      idx   <= 4'd0;
      cnt   <= 8'd0;
      to_q  <= 1'b0;
    end else begin
      state <= nxt_state;
      ptr   <= nxt_ptr;
      idx   <= nxt_idx;
      cnt   <= nxt_cnt;
      to_q  <= nxt_to;
    end
  end

  // next-state logic
  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    nxt_to    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          nxt_state = BUSY;
          nxt_idx   = pick;
          nxt_cnt   = 8'd1;
        end
      end
      BUSY: begin
        if (rel) begin
          nxt_state = IDLE;
          nxt_ptr   = idx + 4'd1;
          nxt_to    = !done && req[idx] && hold_hit;
        end else if (cnt != 8'hFF) begin
          nxt_cnt = cnt + 8'd1;
        end
      end
    endcase
  end

  // outputs decoded from registered state
  always_comb begin
    grant_valid = (state == BUSY);
    grant_idx   = idx;
    grant       = grant_valid ? (16'd1 << idx) : 16'd0;
    timeout     = to_q;
  end

endmodule
